// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-enable toggle, h/v counters, registered syncs and colour,
// plus a one-clk frame_start pulse on every frame wrap (never on the first frame after reset).
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rgb_in,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb_out,
  output logic       frame_start
);

  localparam int unsigned HTotal = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HMax        = 10'(HTotal - 1);
  localparam logic [9:0] VMax        = 10'(VTotal - 1);
  localparam logic [9:0] HDisp       = 10'(H_DISPLAY);
  localparam logic [9:0] VDisp       = 10'(V_DISPLAY);
  localparam logic [9:0] HSyncStart  = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HSyncEnd    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VSyncStart  = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VSyncEnd    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic       tick_q;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [7:0] rgb_q, rgb_d;
  logic       frame_start_q, frame_start_d;
  logic       h_last, v_last;

  assign h_last   = (h_q == HMax);
  assign v_last   = (v_q == VMax);
  assign video_on = (h_q < HDisp) && (v_q < VDisp);

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;
    if (tick_q) begin
      h_d = h_last ? 10'd0 : h_q + 10'd1;
      // v moves on the same edge as the h wrap, so (799,524) goes straight to (0,0)
      if (h_last) begin
        v_d = v_last ? 10'd0 : v_q + 10'd1;
      end
      hsync_d       = !((h_q >= HSyncStart) && (h_q <= HSyncEnd));
      vsync_d       = !((v_q >= VSyncStart) && (v_q <= VSyncEnd));
      rgb_d         = video_on ? rgb_in : 8'h00;
      frame_start_d = h_last && v_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q        <= 1'b0;
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      tick_q        <= ~tick_q;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign pixel_tick  = tick_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb_out     = rgb_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen using reduced timing so whole frames fit in a short run;
// per-clk expectations come from a reference model via a scoreboard queue.
module tb_vga_sync_gen;

  localparam int HD = 16, HF = 2, HS = 4, HB = 3;
  localparam int VD = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rgb_in;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, pixel_tick, hsync, vsync, frame_start;
  logic [7:0] rgb_out;

  vga_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rgb_in     (rgb_in),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .pixel_tick (pixel_tick),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb_out    (rgb_out),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    int         x;
    int         y;
    logic       von;
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
    logic       fs;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic       m_tick, m_hs, m_vs, m_fs;
  logic [7:0] m_rgb;
  int         m_x, m_y;

  // Frame statistics, captured over the first complete frame_start-to-frame_start window
  int  clk_cnt = 0, last_fs = 0, fs_cnt = 0;
  int  acc_hs = 0, acc_vs = 0, acc_rgb = 0, acc_von = 0;
  int  snap_hs = 0, snap_vs = 0, snap_rgb = 0, snap_von = 0, snap_period = 0;
  bit  stats_done = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tick = 1'b0; m_x = 0; m_y = 0;
    m_hs = 1'b1; m_vs = 1'b1; m_rgb = 8'h00; m_fs = 1'b0;
    sb.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tick"}, int'(pixel_tick), 0);
    check({tag, "_x"}, int'(pixel_x), 0);
    check({tag, "_y"}, int'(pixel_y), 0);
    check({tag, "_hsync"}, int'(hsync), 1);
    check({tag, "_vsync"}, int'(vsync), 1);
    check({tag, "_rgb"}, int'(rgb_out), 0);
    check({tag, "_fs"}, int'(frame_start), 0);
  endtask

  // One clk: model predicts, prediction is queued, DUT is sampled #1 after the edge.
  task automatic step();
    exp_t e;
    m_fs = 1'b0;
    if (m_tick) begin
      m_hs  = !(m_x >= HD + HF && m_x <= HD + HF + HS - 1);
      m_vs  = !(m_y >= VD + VF && m_y <= VD + VF + VS - 1);
      m_rgb = (m_x < HD && m_y < VD) ? rgb_in : 8'h00;
      m_fs  = (m_x == HT - 1) && (m_y == VT - 1);
      if (m_x == HT - 1) begin
        m_x = 0;
        m_y = (m_y == VT - 1) ? 0 : m_y + 1;
      end else begin
        m_x = m_x + 1;
      end
    end
    m_tick = !m_tick;
    e.tick = m_tick; e.x = m_x; e.y = m_y;
    e.von  = (m_x < HD) && (m_y < VD);
    e.hs = m_hs; e.vs = m_vs; e.rgb = m_rgb; e.fs = m_fs;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("tick", int'(pixel_tick), int'(e.tick));
    check("pixel_x", int'(pixel_x), e.x);
    check("pixel_y", int'(pixel_y), e.y);
    check("video_on", int'(video_on), int'(e.von));
    check("hsync", int'(hsync), int'(e.hs));
    check("vsync", int'(vsync), int'(e.vs));
    check("rgb_out", int'(rgb_out), int'(e.rgb));
    check("frame_start", int'(frame_start), int'(e.fs));
    clk_cnt++;
    if (frame_start) begin
      if (fs_cnt >= 1 && !stats_done) begin
        snap_hs = acc_hs; snap_vs = acc_vs; snap_rgb = acc_rgb; snap_von = acc_von;
        snap_period = clk_cnt - last_fs;
        stats_done  = 1;
      end
      fs_cnt++;
      last_fs = clk_cnt;
      acc_hs = 0; acc_vs = 0; acc_rgb = 0; acc_von = 0;
    end
    // pixel_tick==0 right after an edge means that edge was a tick: one sample per pixel
    if (!pixel_tick) begin
      if (!hsync) acc_hs++;
      if (!vsync) acc_vs++;
      if (rgb_out == 8'hFF) acc_rgb++;
      if (video_on) acc_von++;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    rgb_in = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");

    // Release between edges; first edge sets tick, second advances x
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rel_tick1", int'(pixel_tick), 1);
    check("rel_x1", int'(pixel_x), 0);
    step();
    check("rel_tick2", int'(pixel_tick), 0);
    check("rel_x2", int'(pixel_x), 1);
    check("rel_y2", int'(pixel_y), 0);

    // Constant white for three frames; first frame after reset must not pulse
    rgb_in = 8'hFF;
    for (int i = 0; i < 3 * HT * VT * 2; i++) step();

    check("stats_window", int'(stats_done), 1);
    check("frame_period", snap_period, HT * VT * 2);
    check("hsync_low_ticks", snap_hs, HS * VT);
    check("vsync_low_ticks", snap_vs, VS * HT);
    check("rgb_ff_ticks", snap_rgb, HD * VD);
    check("video_on_ticks", snap_von, HD * VD);
    check("frame_pulses", fs_cnt, 3);

    // Random colour, then asynchronous reset mid-frame between edges
    begin
      int budget = 2 * HT * VT * 2;
      while (!(m_x == 20 && m_y == 10 && m_tick == 1'b0) && budget > 0) begin
        rgb_in = 8'($urandom);
        step();
        budget--;
      end
      check("reach_reset_point", int'(budget > 0), 1);
    end
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Run through another wrap with random colour
    for (int i = 0; i < HT * VT * 2 + 40; i++) begin
      rgb_in = 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
